// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin register arbiter
package rr_arb_pkg;
  localparam int MAX_N = 16;
  typedef enum logic {IDLE, OWN} state_t;
  function automatic int idx_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
  function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
    int idx;
    idx = 0;
    for (int k = 0; k < MAX_N; k++)
      idx = v[k] ? idx | k : idx;
    return idx;
  endfunction
  function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
    int win, j;
    win = -1;
    for (int k = n - 1; k >= 0; k--) begin
      j = (ptr + k) % n;
      win = req[j] ? j : win;
    end
    return win;
  endfunction
endpackage

// File: rtl/rr_pick_comb.sv
// rr_pick_comb: first set request at or after ptr, wrapping mod N
module rr_pick_comb import rr_arb_pkg::*; #(
  parameter int N = 4,
  localparam int IDXW = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);
  assign found = |req;
  assign idx = IDXW'(rr_pick(MAX_N'(req), int'(ptr), N));
endmodule

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin arbiter sharing one W-bit register among N requesters with bounded lock bursts
module rr_reg_arbiter import rr_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int MAX_HOLD = 4,
  localparam int IDXW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N*W-1:0]  wdata,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] owner,
  output logic [W-1:0]    q,
  output logic            q_valid
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  state_t state;
  logic [IDXW-1:0] ptr, win;
  logic [HW-1:0] hold_cnt;
  logic owner_lock, cont, found;
  logic [N-1:0] others, pick_req;
  assign owner_lock = state == OWN && req[owner] && lock[owner];
  assign cont = owner_lock && hold_cnt < HW'(MAX_HOLD - 1);
  assign others = req & ~gnt;
  assign pick_req = owner_lock && |others ? others : req;
  rr_pick_comb #(.N(N)) u_pick (
    .req(pick_req),
    .ptr(ptr),
    .idx(win),
    .found(found)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      owner <= '0;
      q <= '0;
      q_valid <= 1'b0;
      ptr <= '0;
      hold_cnt <= '0;
      state <= IDLE;
    end else if (cont) begin
      hold_cnt <= hold_cnt + 1'b1;
      q <= wdata[int'(owner)*W +: W];
      q_valid <= 1'b1;
    end else if (found) begin
      gnt <= N'(1) << win;
      owner <= win;
      q <= wdata[int'(win)*W +: W];
      q_valid <= 1'b1;
      ptr <= win == IDXW'(N - 1) ? '0 : win + 1'b1;
      hold_cnt <= '0;
      state <= OWN;
    end else begin
      gnt <= '0;
      q_valid <= 1'b0;
      hold_cnt <= '0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: vector table, corner sequences and randomized model check of rr_reg_arbiter
module tb_rr_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MAX_HOLD = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, lock, gnt;
  logic [N*W-1:0] wdata;
  logic [1:0] owner;
  logic [W-1:0] q;
  logic q_valid;
  int vectors = 0;
  int miscompares = 0;
  int m_own = -1, m_ptr = 0, m_hold = 0, m_oidx = 0;
  bit [W-1:0] m_q = '0;
  bit m_qv = 1'b0;
  typedef struct {
    bit rst;
    bit [N-1:0] req;
    bit [N-1:0] lock;
    bit [N*W-1:0] wd;
    bit [N-1:0] gnt;
    bit [W-1:0] q;
    bit qv;
    int own;
  } vec_t;
  vec_t tbl[18];
  rr_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .lock(lock),
    .wdata(wdata),
    .gnt(gnt),
    .owner(owner),
    .q(q),
    .q_valid(q_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic m_step(input bit r, input bit [N-1:0] rq, input bit [N-1:0] lk, input bit [N*W-1:0] wd);
    bit [N-1:0] cand;
    bit locked;
    if (r) begin
      m_own = -1; m_ptr = 0; m_hold = 0; m_oidx = 0; m_q = '0; m_qv = 1'b0;
      return;
    end
    locked = m_own >= 0 && rq[m_own] && lk[m_own];
    if (locked && m_hold < MAX_HOLD - 1) begin
      m_hold++;
      m_q = wd[m_own*W +: W];
      m_qv = 1'b1;
      return;
    end
    cand = rq;
    if (locked && (rq & ~(N'(1) << m_own)) != 0) cand[m_own] = 1'b0;
    m_hold = 0;
    if (cand == 0) begin
      m_own = -1;
      m_qv = 1'b0;
      return;
    end
    for (int k = 0; k < N; k++)
      if (cand[(m_ptr + k) % N]) begin
        m_own = (m_ptr + k) % N;
        break;
      end
    m_oidx = m_own;
    m_ptr = (m_own + 1) % N;
    m_q = wd[m_own*W +: W];
    m_qv = 1'b1;
  endtask
  task automatic step(input bit r, input bit [N-1:0] rq, input bit [N-1:0] lk, input bit [N*W-1:0] wd);
    rst = r; req = rq; lock = lk; wdata = wd;
    @(posedge clk);
    m_step(r, rq, lk, wd);
    #1;
  endtask
  initial begin
    bit r;
    bit [N-1:0] rq, lk;
    bit [N*W-1:0] wd;
    tbl = '{
      '{1, 4'hf, 4'h0, 32'h44332211, 4'h0, 8'h00, 0, 0},
      '{1, 4'hf, 4'h0, 32'h44332211, 4'h0, 8'h00, 0, 0},
      '{0, 4'hf, 4'h0, 32'h44332211, 4'h1, 8'h11, 1, 0},
      '{0, 4'hf, 4'h0, 32'h44332211, 4'h2, 8'h22, 1, 1},
      '{0, 4'hf, 4'h0, 32'h44332211, 4'h4, 8'h33, 1, 2},
      '{0, 4'hf, 4'h0, 32'h44332211, 4'h8, 8'h44, 1, 3},
      '{0, 4'hf, 4'h0, 32'h44332211, 4'h1, 8'h11, 1, 0},
      '{0, 4'h9, 4'h0, 32'h44332211, 4'h8, 8'h44, 1, 3},
      '{0, 4'h9, 4'h0, 32'h44332211, 4'h1, 8'h11, 1, 0},
      '{0, 4'h9, 4'h0, 32'h44332211, 4'h8, 8'h44, 1, 3},
      '{0, 4'h0, 4'h0, 32'h44332211, 4'h0, 8'h44, 0, 0},
      '{0, 4'h4, 4'h0, 32'h44332211, 4'h4, 8'h33, 1, 2},
      '{0, 4'h3, 4'h1, 32'h44332211, 4'h1, 8'h11, 1, 0},
      '{0, 4'h3, 4'h1, 32'h4433225a, 4'h1, 8'h5a, 1, 0},
      '{0, 4'h3, 4'h1, 32'h44332211, 4'h1, 8'h11, 1, 0},
      '{0, 4'h3, 4'h1, 32'h44332211, 4'h1, 8'h11, 1, 0},
      '{0, 4'h3, 4'h1, 32'h44332211, 4'h2, 8'h22, 1, 1},
      '{0, 4'h3, 4'h1, 32'h44332211, 4'h1, 8'h11, 1, 0}
    };
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].wd);
      chk($sformatf("tbl%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d q", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("tbl%0d q_valid", i), 32'(q_valid), 32'(tbl[i].qv));
      if (tbl[i].qv || tbl[i].rst) chk($sformatf("tbl%0d owner", i), 32'(owner), 32'(tbl[i].own));
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 4'h1, 4'h1, {24'h443322, 8'(8'h60 + i)});
      chk($sformatf("sole%0d gnt", i), 32'(gnt), 32'h1);
      chk($sformatf("sole%0d q_valid", i), 32'(q_valid), 32'h1);
      chk($sformatf("sole%0d q", i), 32'(q), 32'(8'h60 + i));
    end
    step(0, 4'h4, 4'h4, 32'h44332211);
    chk("burst2 first gnt", 32'(gnt), 32'h4);
    step(0, 4'h4, 4'h4, 32'h44332211);
    chk("burst2 held gnt", 32'(gnt), 32'h4);
    step(1, 4'h4, 4'h4, 32'h44332211);
    chk("midrst gnt", 32'(gnt), 32'h0);
    chk("midrst q", 32'(q), 32'h0);
    chk("midrst q_valid", 32'(q_valid), 32'h0);
    chk("midrst owner", 32'(owner), 32'h0);
    step(0, 4'h6, 4'h0, 32'h44332211);
    chk("postrst gnt", 32'(gnt), 32'h2);
    chk("postrst owner", 32'(owner), 32'h1);
    chk("postrst q", 32'(q), 32'h22);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 39) == 0;
      rq = N'($urandom);
      lk = N'($urandom);
      wd = {$urandom};
      step(r, rq, lk, wd);
      chk($sformatf("rnd%0d gnt", i), 32'(gnt), m_own >= 0 ? 32'(1) << m_own : 32'h0);
      chk($sformatf("rnd%0d q", i), 32'(q), 32'(m_q));
      chk($sformatf("rnd%0d q_valid", i), 32'(q_valid), 32'(m_qv));
      if (m_qv) chk($sformatf("rnd%0d owner", i), 32'(owner), 32'(m_oidx));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
